// File: rtl/iter_div.sv
// iter_div: restoring radix-2 divider, one quotient bit per clock, signed/unsigned with
// div-by-zero and overflow results fixed at completion.
module iter_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              div_flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_neg_q, r_neg_r, r_dz;
    logic [DATA_W-1:0] r_src1, r_divisor, r_rem, r_dvd, r_quot, r_remd;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_diff, w_rem_next, w_q_next, w_q_fix, w_r_fix, w_mag1, w_mag2;
    logic              w_ok, w_last, w_accept;

    assign w_accept   = (r_state == IDLE) && div_valid && !div_flush;
    assign w_last     = r_cnt == CW'(DATA_W - 1);
    assign w_mag1     = (div_signed && div_src1[DATA_W-1]) ? -div_src1 : div_src1;
    assign w_mag2     = (div_signed && div_src2[DATA_W-1]) ? -div_src2 : div_src2;
    // The shifted remainder is below 2*divisor, so when the trial succeeds the
    // low DATA_W bits of the difference are exact.
    assign w_shift    = {r_rem, r_dvd[DATA_W-1]};
    assign w_ok       = w_shift >= {1'b0, r_divisor};
    assign w_diff     = w_shift[DATA_W-1:0] - r_divisor;
    assign w_rem_next = w_ok ? w_diff : w_shift[DATA_W-1:0];
    assign w_q_next   = {r_dvd[DATA_W-2:0], w_ok};
    assign w_q_fix    = r_neg_q ? -w_q_next : w_q_next;
    assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;

    assign div_ready = r_state == IDLE;
    assign res_valid = r_state == DONE;
    assign quotient  = r_quot;
    assign remainder = r_remd;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = BUSY;
        if (r_state == BUSY && w_last) w_next = DONE;
        if (r_state == DONE && res_ready) w_next = IDLE;
        if (div_flush) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_remd <= '0;
        end else if (w_accept) begin
            r_neg_q   <= div_signed && (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
            r_neg_r   <= div_signed && div_src1[DATA_W-1];
            r_dz      <= div_src2 == '0;
            r_src1    <= div_src1;
            r_divisor <= w_mag2;
            r_dvd     <= w_mag1;
            r_rem     <= '0;
            r_cnt     <= '0;
        end else if (r_state == BUSY && !div_flush) begin
            r_rem <= w_rem_next;
            r_dvd <= w_q_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_quot <= r_dz ? '1 : w_q_fix;
                r_remd <= r_dz ? r_src1 : w_r_fix;
            end
        end
    end
endmodule

// File: doc/iter_div.md
# iter_div

Parametrised multi-cycle integer divider for the LoongArch core: a restoring radix-2 divider that retires one quotient bit per clock. It sits beside the single-cycle ALU in the execute stage and serves div.w, mod.w, div.wu and mod.wu. A valid/ready handshake on each side lets the pipeline stall while a division runs.

## Interface
Parameters:
- DATA_W, 32: operand and result width; legal range 4 to 64.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset, sampled on the rising clk edge.
- div_valid  in  1  request valid.
- div_ready  out  1  divider can accept a request (state IDLE).
- div_signed  in  1  1 = signed (two's complement), 0 = unsigned; sampled at accept.
- div_src1  in  DATA_W  dividend; sampled at accept.
- div_src2  in  DATA_W  divisor; sampled at accept.
- div_flush  in  1  abandon any in-flight or completed operation (pipeline cancel).
- res_valid  out  1  quotient and remainder valid (state DONE).
- res_ready  in  1  consumer takes the result.
- quotient  out  DATA_W  quotient, truncated toward zero.
- remainder  out  DATA_W  remainder; sign follows the dividend.

## Operation
- States: IDLE, BUSY, DONE. div_ready = (state==IDLE); res_valid = (state==DONE).
- IDLE: on div_valid && div_ready, latch div_signed, sign(src1), sign(src2), |src1| and |src2| (magnitudes only when signed), and a div-by-zero flag (src2==0). Clear the iteration counter. Go to BUSY.
- BUSY: one iteration per cycle. Shift {partial remainder, dividend} left by 1. Trial-subtract the divisor (DATA_W+1-bit subtract). If the result is non-negative, keep it and shift in quotient bit 1, else 0.
- Counter width is clog2(DATA_W)+1. After iteration DATA_W, go to DONE and register the final quotient and remainder.
- Sign fix, applied when the final results are registered:
  - Signed: quotient negated when the operand signs differ; remainder negated when the dividend is negative.
  - Unsigned: no correction.
- Divide by zero, signed or unsigned: quotient = all ones, remainder = original div_src1.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0. No exception or flag.
- DONE: quotient and remainder held stable while res_valid is high and res_ready is low. On res_valid && res_ready, go to IDLE.
- div_valid is ignored outside IDLE; operands must not be sampled.
- div_flush has top priority over every transition except reset: next state IDLE, operation discarded, quotient and remainder not updated.
- div_flush and div_valid in the same IDLE cycle: the request is not accepted.

## Timing
- Reset (resetn low at an edge): state IDLE, counter 0, quotient 0, remainder 0.
  - After that edge: div_ready=1, res_valid=0.
  - Reset in BUSY or DONE aborts identically.
- Accept at edge E0. Iterations occur at edges E1..E_DATA_W. res_valid is first high in the cycle after E_DATA_W, i.e. DATA_W+1 cycles after the accept cycle; 33 for DATA_W=32.
- Latency does not depend on operand values (no early-out).
- Divide by zero and overflow take the same latency.
- A result taken at edge Ek returns to IDLE, so div_ready=1 in cycle k+1. The minimum initiation interval is DATA_W+2 cycles with res_ready held high.
- Outputs are registered; there is no combinational path from div_valid, div_src1 or div_src2 to any output.

## Test plan
- Unsigned, DATA_W=32, 100 / 7 with res_ready=1 -> quotient 14, remainder 2. res_valid high exactly 33 cycles after accept, for one cycle, then div_ready=1.
- Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1. Unsigned 0xFFFFFFF9/2 -> quotient 0x7FFFFFFC, remainder 1.
- Corner values:
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - 0x1234 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 0x1234.
  - Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> outputs unchanged and res_valid held. A div_valid pulse with new operands while BUSY/DONE is ignored; the result is still for the original op.
- Flush: assert div_flush at iteration 10 -> IDLE next cycle, div_ready=1, res_valid never rises. The following op 50/5 yields quotient 10, remainder 0 after 33 cycles.
- Reset mid-BUSY and in DONE -> next cycle div_ready=1, res_valid=0, quotient=remainder=0. Repeat with DATA_W=8: signed -128/3 -> quotient 0xD6, remainder 0xFE, latency 9 cycles.
